// File: rtl/slzd_rx_pkg.sv
// Shared constants and state encoding for the serialized frame receiver.
// Optional fixed-stuff support is controlled by SLZD_RX_FXD_STUFF_EN.
package slzd_rx_pkg;

  typedef enum logic [1:0] {
    INTEG = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2
  } rx_state_t;

  localparam logic [2:0] STUFF_LEN     = 3'd5;
  localparam logic [3:0] FXD_STUFF_LEN = 4'd10;
  localparam logic [3:0] IDLE_LEN      = 4'd11;
  localparam logic [2:0] DOM_FLAG_LEN  = 3'd6;

endpackage

// File: rtl/slzd_destuff.sv
// Stuff-bit removal: dynamic run-length destuffing and, with SLZD_RX_FXD_STUFF_EN,
// fixed stuffing (one inverted bit after every FXD_STUFF_LEN data bits).
module slzd_destuff
  import slzd_rx_pkg::*;
(
  input  logic clk,
  input  logic i_rst,
  input  logic i_sample,
  input  logic i_sof_load,
  input  logic i_active,
  input  logic i_stuff_en,
  input  logic i_fxd_stf_en,
  output logic o_deliver,
  output logic o_stuff_err
);

  logic       r_prev_bit;
  logic [2:0] r_same_cnt;
  logic       w_prev_nxt;
  logic [2:0] w_same_nxt;

`ifdef SLZD_RX_FXD_STUFF_EN
  logic [3:0] r_fxd_cnt;
  logic       r_fxd_en_d;
  logic [3:0] w_fxd_cnt_eff;
  logic [3:0] w_fxd_nxt;

  // A fresh fixed-stuff region always starts counting from zero.
  assign w_fxd_cnt_eff = (i_fxd_stf_en && !r_fxd_en_d) ? 4'd0 : r_fxd_cnt;
`else
  logic w_unused_fxd;
  assign w_unused_fxd = i_fxd_stf_en;
`endif

  always_comb begin
    w_prev_nxt  = r_prev_bit;
    w_same_nxt  = r_same_cnt;
    o_deliver   = 1'b0;
    o_stuff_err = 1'b0;
`ifdef SLZD_RX_FXD_STUFF_EN
    w_fxd_nxt   = w_fxd_cnt_eff;
`endif
    if (i_sof_load) begin
      w_prev_nxt = 1'b0;
      w_same_nxt = 3'd1;
`ifdef SLZD_RX_FXD_STUFF_EN
      w_fxd_nxt  = 4'd0;
`endif
    end else if (i_active) begin
`ifdef SLZD_RX_FXD_STUFF_EN
      if (i_fxd_stf_en) begin
        if (w_fxd_cnt_eff == FXD_STUFF_LEN) begin
          o_stuff_err = (i_sample == r_prev_bit);
          w_fxd_nxt   = 4'd0;
        end else begin
          o_deliver = 1'b1;
          w_fxd_nxt = w_fxd_cnt_eff + 4'd1;
        end
        w_prev_nxt = i_sample;
        w_same_nxt = 3'd1;
      end else
`endif
      if (!i_stuff_en) begin
        o_deliver  = 1'b1;
        w_prev_nxt = i_sample;
        w_same_nxt = 3'd1;
      end else if (r_same_cnt == STUFF_LEN) begin
        // Stuff position: a bad stuff bit still resyncs the run history.
        o_stuff_err = (i_sample == r_prev_bit);
        w_prev_nxt  = i_sample;
        w_same_nxt  = 3'd1;
      end else begin
        o_deliver  = 1'b1;
        w_same_nxt = (i_sample == r_prev_bit) ? r_same_cnt + 3'd1 : 3'd1;
        w_prev_nxt = i_sample;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev_bit <= 1'b1;
      r_same_cnt <= 3'd0;
    end else begin
      r_prev_bit <= w_prev_nxt;
      r_same_cnt <= w_same_nxt;
    end
  end

`ifdef SLZD_RX_FXD_STUFF_EN
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_fxd_cnt  <= 4'd0;
      r_fxd_en_d <= 1'b0;
    end else begin
      r_fxd_cnt  <= w_fxd_nxt;
      r_fxd_en_d <= i_fxd_stf_en;
    end
  end
`endif

endmodule

// File: rtl/slzd_frm_rx.sv
// Serialized CAN/CAN XL frame receiver: bus integration, SOF, destuffing, bit monitoring.
// Fixed stuffing for the XL data phase is built only with SLZD_RX_FXD_STUFF_EN.
module slzd_frm_rx
  import slzd_rx_pkg::*;
(
  input  logic clk,
  input  logic g_rst,
  input  logic can_bus_in,
  input  logic tx_active,
  input  logic tx_bit_mon,
  input  logic arbtr_field,
  input  logic ack_slot,
  input  logic stuff_en,
  input  logic fxd_stf_en,
  input  logic frm_end,
  output logic rx_bit,
  output logic rx_bit_vld,
  output logic sof_det,
  output logic stuff_err,
  output logic bit_err,
  output logic arb_lost,
  output logic dom6_det,
  output logic bus_idle
);

  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic [3:0] r_rec_cnt;
  logic [3:0] w_rec_nxt;
  logic [2:0] r_dom_cnt;
  logic [2:0] w_dom_nxt;
  logic       w_sof;
  logic       w_active;
  logic       w_deliver;
  logic       w_stuff_err;
  logic       w_mismatch;
  logic       w_arb_lost;
  logic       w_bit_err;
  logic       w_dom6;

  always_comb begin
    w_state_nxt = r_state;
    w_sof       = 1'b0;
    unique case (r_state)
      INTEG: if (w_rec_nxt == IDLE_LEN) w_state_nxt = IDLE;
      IDLE: begin
        if (!can_bus_in) begin
          w_state_nxt = FRAME;
          w_sof       = 1'b1;
        end
      end
      FRAME: if (frm_end) w_state_nxt = IDLE;
      default: w_state_nxt = INTEG;
    endcase
  end

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) r_state <= INTEG;
    else       r_state <= w_state_nxt;
  end

  assign w_rec_nxt = !can_bus_in ? 4'd0 :
                     (r_rec_cnt == IDLE_LEN) ? r_rec_cnt : r_rec_cnt + 4'd1;
  assign w_dom_nxt = can_bus_in ? 3'd0 :
                     (r_dom_cnt == DOM_FLAG_LEN) ? r_dom_cnt : r_dom_cnt + 3'd1;
  assign w_dom6    = !can_bus_in && (r_dom_cnt == DOM_FLAG_LEN - 3'd1);

  // The sample that coincides with frm_end belongs to no frame.
  assign w_active = (r_state == FRAME) && !frm_end;

  assign w_mismatch = tx_active && (can_bus_in != tx_bit_mon);
  assign w_arb_lost = w_mismatch && arbtr_field && tx_bit_mon;
  assign w_bit_err  = w_mismatch && !(tx_bit_mon && (arbtr_field || ack_slot));

  slzd_destuff u_destuff (
    .clk          (clk),
    .i_rst        (g_rst),
    .i_sample     (can_bus_in),
    .i_sof_load   (w_sof),
    .i_active     (w_active),
    .i_stuff_en   (stuff_en),
    .i_fxd_stf_en (fxd_stf_en),
    .o_deliver    (w_deliver),
    .o_stuff_err  (w_stuff_err)
  );

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_rec_cnt  <= 4'd0;
      r_dom_cnt  <= 3'd0;
      rx_bit     <= 1'b1;
      rx_bit_vld <= 1'b0;
      sof_det    <= 1'b0;
      stuff_err  <= 1'b0;
      bit_err    <= 1'b0;
      arb_lost   <= 1'b0;
      dom6_det   <= 1'b0;
      bus_idle   <= 1'b0;
    end else begin
      r_rec_cnt  <= w_rec_nxt;
      r_dom_cnt  <= w_dom_nxt;
      if (w_sof || w_deliver) rx_bit <= can_bus_in;
      rx_bit_vld <= w_sof || w_deliver;
      sof_det    <= w_sof;
      stuff_err  <= w_stuff_err;
      bit_err    <= w_bit_err;
      arb_lost   <= w_arb_lost;
      dom6_det   <= w_dom6;
      bus_idle   <= (w_rec_nxt >= IDLE_LEN);
    end
  end

endmodule

// File: doc/slzd_frm_rx.md
# slzd_frm_rx

Serialized frame receiver for the CAN/CAN XL controller; the receive-side counterpart of the serialized frame transmitter. It samples one bus bit per `clk` (one clock per bit time) and integrates onto the bus after reset. It detects SOF, removes dynamic stuff bits and flags stuff errors, monitors transmitted bits for bit error and arbitration loss, and reports bus idle and six-dominant error flags. Destuffed bits go to the frame decoder; error pulses go to the error-confinement logic.

## Interface
- No parameters; constants live in `slzd_rx_pkg`.
- `clk` in 1: bit-rate clock; one sample per rising edge.
- `g_rst` in 1: asynchronous, active-high reset.
- `can_bus_in` in 1: sampled bus level (0 = dominant).
- `tx_active` in 1: this node is currently a transmitter.
- `tx_bit_mon` in 1: level this node drove for the bit being sampled.
- `arbtr_field` in 1: current bit is in the arbitration field.
- `ack_slot` in 1: current bit is the ACK slot.
- `stuff_en` in 1: current bit lies in a stuffed region.
- `fxd_stf_en` in 1: fixed-stuffing region (CAN XL data phase); see Configuration.
- `frm_end` in 1: pulse from the frame decoder at end of EOF/intermission.
- `rx_bit` out 1: destuffed data bit.
- `rx_bit_vld` out 1: one-cycle pulse; `rx_bit` is valid.
- `sof_det` out 1: one-cycle pulse on SOF.
- `stuff_err` out 1: one-cycle pulse.
- `bit_err` out 1: one-cycle pulse.
- `arb_lost` out 1: one-cycle pulse.
- `dom6_det` out 1: one-cycle pulse on the 6th consecutive dominant sample.
- `bus_idle` out 1: level; at least 11 consecutive recessive samples seen.

## Operation
- States: INTEG (after reset), IDLE, FRAME.
- Recessive counter: 4 bits, increments on each recessive sample, clears on dominant, saturates at 11.
  - `bus_idle` = counter ≥ 11.
  - INTEG → IDLE when the counter reaches 11.
  - Dominant samples in INTEG only clear the counter.
- IDLE → FRAME on a dominant sample:
  - Pulse `sof_det` and `rx_bit_vld` with `rx_bit=0`.
  - Load stuff history: `prev_bit=0`, `same_cnt=1`.
- FRAME → IDLE on `frm_end`. `frm_end` has priority over any same-cycle sample; that sample is not an SOF and is not delivered.
- Dynamic destuffing in FRAME:
  - Applies when `stuff_en=1` and `fxd_stf_en=0`.
  - `same_cnt` (3 bits) counts consecutive equal bits, including stuff bits.
  - When `same_cnt==5`, the next sample is the stuff bit.
    - If it equals `prev_bit`: pulse `stuff_err`.
    - Otherwise: drop it (no `rx_bit_vld`), set `same_cnt=1`, `prev_bit` = sample.
  - When `stuff_en=0`: every sample is delivered and `same_cnt` is held at 1 with `prev_bit` = sample.
- Bit monitoring, every state:
  - Applies when `tx_active=1` and sample ≠ `tx_bit_mon`.
  - `arbtr_field=1` and `tx_bit_mon=1` → `arb_lost` (no `bit_err`).
  - `ack_slot=1` and `tx_bit_mon=1` → ignored.
  - Otherwise → `bit_err`.
  - Stuff bits are monitored as well.
- Dominant counter: 3 bits, clears on recessive; `dom6_det` pulses once when it reaches 6, then saturates with no repeat pulse.
- Simultaneous events: `stuff_err`, `bit_err` and `dom6_det` may pulse in the same cycle; each is reported independently.

## Timing
- All outputs are registered. Each output reflects the sample taken on the previous edge: latency is 1 clk from sample to `rx_bit`/`rx_bit_vld`/error pulses.
- Pulses are exactly one cycle wide. `rx_bit` holds its value between valid pulses.
- Reset values:
  - State INTEG; all counters 0; `prev_bit=1`.
  - `rx_bit=1`.
  - `rx_bit_vld`, `sof_det`, `stuff_err`, `bit_err`, `arb_lost`, `dom6_det`, `bus_idle` all 0.
- Reset asserted mid-frame aborts immediately. No pulses are issued during reset or in the cycle it releases. The block re-integrates: 11 recessive samples are required before the next SOF.

## Configuration
- `SLZD_RX_FXD_STUFF_EN` defined: when `fxd_stf_en=1` in FRAME, dynamic stuffing is suspended.
  - A 4-bit counter counts delivered bits.
  - After every 10th bit, one stuff bit is expected equal to the inverse of the last data bit. It is dropped; a mismatch pulses `stuff_err`. The counter then restarts.
  - On the rising edge of `fxd_stf_en`, the counter starts at 0.
- `SLZD_RX_FXD_STUFF_EN` undefined: `fxd_stf_en` is ignored and only dynamic stuffing exists; the fixed-stuff counter is not built.

## Structure
- `slzd_rx_pkg` holds:
  - State encodings: INTEG=2'd0, IDLE=2'd1, FRAME=2'd2.
  - `STUFF_LEN=5`, `FXD_STUFF_LEN=10`, `IDLE_LEN=11`, `DOM_FLAG_LEN=6`.
- One sub-module, `slzd_destuff`: `same_cnt`/`prev_bit` tracking, the optional fixed-stuff counter, the drop/`stuff_err` decision. The top level keeps the state machine, idle/dominant counters and bit monitoring.

## Test plan
- Reset, 10 recessive then 1 dominant → no `sof_det`, `bus_idle=0`. Then 11 recessive → `bus_idle=1`. Then dominant → `sof_det`=1 and `rx_bit_vld`=1 with `rx_bit=0`, one cycle later.
- FRAME with `stuff_en=1`: SOF 0, then 0,0,0,0 → 5 valid zeros; then 1 (stuff) → no `rx_bit_vld`; then 1 → valid `rx_bit=1`.
- SOF followed by five more 0s, `stuff_en=1` → `stuff_err` and `dom6_det` both pulse in the cycle after the 6th dominant.
- `tx_active=1`, `tx_bit_mon=1`, bus 0:
  - `arbtr_field=1` → `arb_lost` only.
  - `arbtr_field=0`, `ack_slot=1` → no pulse.
  - Both 0 → `bit_err`.
- With `SLZD_RX_FXD_STUFF_EN`, `fxd_stf_en=1`:
  - 10 bits ending in 1, then 0 → stuff bit dropped, no error.
  - Repeat with stuff bit 1 → `stuff_err`.
- Assert `g_rst` mid-FRAME → all outputs at reset values. After release, a dominant sample produces no `sof_det` until 11 recessive samples are seen.
